// File: rtl/fpu_pkg.sv
// Shared FP back-end definitions: func5 encodings, destination classes and
// the pipeline-register entry carried through MEM and WB.
package fpu_pkg;

  localparam int FLEN = 32;

  localparam logic [4:0] F5_ADD       = 5'b00000;
  localparam logic [4:0] F5_SUB       = 5'b00001;
  localparam logic [4:0] F5_MUL       = 5'b00010;
  localparam logic [4:0] F5_MIN_MAX   = 5'b00101;
  localparam logic [4:0] F5_FCVTWS    = 5'b11000;
  localparam logic [4:0] F5_FCVTSW    = 5'b11010;
  localparam logic [4:0] F5_FMVXW     = 5'b11100;
  localparam logic [4:0] F5_FMVWX     = 5'b11110;
  localparam logic [4:0] F5_FEQ_LT_LE = 5'b10100;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_FP   = 2'd1,
    DST_INT  = 2'd2
  } dst_cls_e;

  typedef struct packed {
    logic            valid;
    dst_cls_e        cls;
    logic [4:0]      rd;
    logic [FLEN-1:0] data;
  } pipe_entry_t;

  function automatic dst_cls_e decode_cls(input logic [4:0] func5);
    dst_cls_e cls;
    case (func5)
      F5_FCVTWS, F5_FMVXW, F5_FEQ_LT_LE:                  cls = DST_INT;
      F5_ADD, F5_SUB, F5_MUL, F5_MIN_MAX, F5_FCVTSW, F5_FMVWX: cls = DST_FP;
      default:                                            cls = DST_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/fp_regfile.sv
// 32-entry FP register file: two async read ports with write-first bypass,
// one synchronous write port, synchronous active-low clear of all entries.
module fp_regfile
  import fpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Write-first: a reader in the commit cycle sees the value being written.
  assign rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
  assign rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];

endmodule

// File: rtl/fpu_wb_regfile.sv
// FP back end: EX->MEM->WB pipeline registers, commit to the FP or integer
// file, decode read ports with WB bypass and EX operand forwarding.
module fpu_wb_regfile
  import fpu_pkg::*;
#(
  parameter int XLEN = FLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            e_valid,
  input  logic [4:0]      e_func5,
  input  logic [4:0]      e_rd,
  input  logic [XLEN-1:0] e_result,
  input  logic [4:0]      e_frs1,
  input  logic [4:0]      e_frs2,
  input  logic [XLEN-1:0] e_op1_in,
  input  logic [XLEN-1:0] e_op2_in,
  output logic [XLEN-1:0] e_op1,
  output logic [XLEN-1:0] e_op2,
  input  logic [4:0]      d_frs1,
  input  logic [4:0]      d_frs2,
  output logic [XLEN-1:0] d_frs1_data,
  output logic [XLEN-1:0] d_frs2_data,
  output logic            w_int_we,
  output logic [4:0]      w_int_rd,
  output logic [XLEN-1:0] w_int_data,
  output logic [31:0]     fp_retired
);

  pipe_entry_t m_q, m_d, w_q, w_d;
  logic [31:0] retired_q, retired_d;
  logic        fp_we;
  logic        int_we;

  always_comb begin
    m_d = m_q;
    w_d = w_q;
    if (!stall) begin
      w_d = m_q;
      if (flush || !e_valid) begin
        m_d = '0;
      end else begin
        m_d.valid = 1'b1;
        m_d.cls   = decode_cls(e_func5);
        m_d.rd    = e_rd;
        m_d.data  = e_result;
      end
    end
  end

  // Commits are gated by rst so an in-flight W entry is dropped, not written.
  assign fp_we  = rst && !stall && w_q.valid && (w_q.cls == DST_FP);
  assign int_we = rst && !stall && w_q.valid && (w_q.cls == DST_INT);

  assign retired_d = fp_we ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_q       <= '0;
      w_q       <= '0;
      retired_q <= '0;
    end else begin
      m_q       <= m_d;
      w_q       <= w_d;
      retired_q <= retired_d;
    end
  end

  fp_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (fp_we),
    .waddr_i  (w_q.rd),
    .wdata_i  (w_q.data),
    .raddr1_i (d_frs1),
    .raddr2_i (d_frs2),
    .rdata1_o (d_frs1_data),
    .rdata2_o (d_frs2_data)
  );

  logic m_fp, w_fp;
  assign m_fp = m_q.valid && (m_q.cls == DST_FP);
  assign w_fp = w_q.valid && (w_q.cls == DST_FP);

  // The younger M entry wins when both stages target the same register.
  always_comb begin
    e_op1 = e_op1_in;
    e_op2 = e_op2_in;
    if (m_fp && (m_q.rd == e_frs1))      e_op1 = m_q.data;
    else if (w_fp && (w_q.rd == e_frs1)) e_op1 = w_q.data;
    if (m_fp && (m_q.rd == e_frs2))      e_op2 = m_q.data;
    else if (w_fp && (w_q.rd == e_frs2)) e_op2 = w_q.data;
  end

  assign w_int_we   = int_we;
  assign w_int_rd   = int_we ? w_q.rd   : '0;
  assign w_int_data = int_we ? w_q.data : '0;
  assign fp_retired = retired_q;

endmodule
